// File: rtl/prv_trap_ctrl_if.sv
// Privilege/pipeline trap connection: hazard flags, interrupts and CSR values in; redirect and CSR strobes out.
// Pure wiring, no latency.
// No backpressure: the hazard unit holds its requests until the pipeline restarts.
interface prv_trap_ctrl_if;
    // exception flags from the hazard unit
    logic        fault_insn;
    logic        mal_insn;
    logic        illegal_insn;
    logic        fault_l;
    logic        mal_l;
    logic        fault_s;
    logic        mal_s;
    logic        breakpoint;
    logic        env;
    logic        fault_insn_page;
    logic        fault_load_page;
    logic        fault_store_page;
    // xRET / WFI requests and drain status
    logic        mret;
    logic        sret;
    logic        wfi;
    logic        pipe_clear;
    logic [31:0] epc;
    logic [31:0] badaddr;
    // interrupts (already masked by mie) and CSR state
    logic        timer_int;
    logic        soft_int;
    logic        ext_int;
    logic        mstatus_mie;
    logic [1:0]  curr_privilege_level;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] sepc;
    // redirect and CSR update results
    logic [31:0] priv_pc;
    logic        insert_pc;
    logic        intr;
    logic        trap_take;
    logic        mret_take;
    logic        sret_take;
    logic [31:0] cause_out;
    logic [31:0] epc_out;
    logic [31:0] tval_out;

    // trap sequencer side
    modport slave (
        input  fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
               breakpoint, env, fault_insn_page, fault_load_page, fault_store_page,
               mret, sret, wfi, pipe_clear, epc, badaddr,
               timer_int, soft_int, ext_int, mstatus_mie, curr_privilege_level,
               mtvec, mepc, sepc,
        output priv_pc, insert_pc, intr, trap_take, mret_take, sret_take,
               cause_out, epc_out, tval_out
    );

    // hazard unit / CSR file side
    modport master (
        output fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
               breakpoint, env, fault_insn_page, fault_load_page, fault_store_page,
               mret, sret, wfi, pipe_clear, epc, badaddr,
               timer_int, soft_int, ext_int, mstatus_mie, curr_privilege_level,
               mtvec, mepc, sepc,
        input  priv_pc, insert_pc, intr, trap_take, mret_take, sret_take,
               cause_out, epc_out, tval_out
    );
endinterface

// File: rtl/prv_trap_ctrl.sv
// Trap sequencer: arbitrates exceptions > interrupts > mret > sret > wfi, drains the pipe, then redirects.
// Latency: request to insert_pc is 2 cycles minimum, else 1 cycle after the first pipe_clear.
// Backpressure: waits in DRAIN for pipe_clear; requests seen in DRAIN/REDIRECT are ignored.
// Optional macro PRV_VECTORED_TRAP_EN enables vectored interrupt targets (mtvec mode 01).
module prv_trap_ctrl (
    input  logic           CLK,
    input  logic           nRST,
    prv_trap_ctrl_if.slave pif
);
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_SLEEP    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_TRAP = 2'd0,
        K_MRET = 2'd1,
        K_SRET = 2'd2
    } kind_t;

    // exception cause codes
    localparam word_t C_MAL_INSN       = 32'd0;
    localparam word_t C_FAULT_INSN     = 32'd1;
    localparam word_t C_ILLEGAL_INSN   = 32'd2;
    localparam word_t C_BREAKPOINT     = 32'd3;
    localparam word_t C_MAL_L          = 32'd4;
    localparam word_t C_FAULT_L        = 32'd5;
    localparam word_t C_MAL_S          = 32'd6;
    localparam word_t C_FAULT_S        = 32'd7;
    localparam word_t C_ENV_U          = 32'd8;
    localparam word_t C_ENV_S          = 32'd9;
    localparam word_t C_ENV_M          = 32'd11;
    localparam word_t C_INSN_PAGE      = 32'd12;
    localparam word_t C_LOAD_PAGE      = 32'd13;
    localparam word_t C_STORE_PAGE     = 32'd15;
    // interrupt cause codes (bit 31 set)
    localparam word_t C_INT_SOFT       = 32'h8000_0003;
    localparam word_t C_INT_TIMER      = 32'h8000_0007;
    localparam word_t C_INT_EXT        = 32'h8000_000B;

    state_t state;
    kind_t  kind;
    word_t  cause_r;
    word_t  epc_r;
    word_t  tval_r;
    word_t  priv_pc_r;
    logic   intr_r;

    logic   exc_vld;
    word_t  exc_cause;
    word_t  exc_tval;
    word_t  env_cause;

    logic   int_pend;
    logic   int_take;
    word_t  int_cause;

    word_t  tvec_base;
    word_t  trap_tgt;
    word_t  redirect_pc;

    // environment call cause depends on the privilege it was issued from
    always_comb begin
        env_cause = C_ENV_M;
        case (pif.curr_privilege_level)
            2'd0:    env_cause = C_ENV_U;
            2'd1:    env_cause = C_ENV_S;
            default: env_cause = C_ENV_M;
        endcase
    end

    // highest-priority exception with its tval (epc for fetch-side, badaddr for data-side)
    always_comb begin
        exc_vld   = 1'b1;
        exc_cause = '0;
        exc_tval  = '0;
        if (pif.breakpoint) begin
            exc_cause = C_BREAKPOINT;
        end else if (pif.fault_insn_page) begin
            exc_cause = C_INSN_PAGE;
            exc_tval  = pif.epc;
        end else if (pif.fault_insn) begin
            exc_cause = C_FAULT_INSN;
            exc_tval  = pif.epc;
        end else if (pif.mal_insn) begin
            exc_cause = C_MAL_INSN;
            exc_tval  = pif.epc;
        end else if (pif.illegal_insn) begin
            exc_cause = C_ILLEGAL_INSN;
            exc_tval  = pif.epc;
        end else if (pif.env) begin
            exc_cause = env_cause;
        end else if (pif.mal_s) begin
            exc_cause = C_MAL_S;
            exc_tval  = pif.badaddr;
        end else if (pif.mal_l) begin
            exc_cause = C_MAL_L;
            exc_tval  = pif.badaddr;
        end else if (pif.fault_store_page) begin
            exc_cause = C_STORE_PAGE;
            exc_tval  = pif.badaddr;
        end else if (pif.fault_load_page) begin
            exc_cause = C_LOAD_PAGE;
            exc_tval  = pif.badaddr;
        end else if (pif.fault_s) begin
            exc_cause = C_FAULT_S;
            exc_tval  = pif.badaddr;
        end else if (pif.fault_l) begin
            exc_cause = C_FAULT_L;
            exc_tval  = pif.badaddr;
        end else begin
            exc_vld   = 1'b0;
        end
    end

    assign int_pend = pif.timer_int | pif.soft_int | pif.ext_int;
    assign int_take = int_pend & pif.mstatus_mie;

    // interrupt priority: external, then software, then timer
    always_comb begin
        int_cause = C_INT_TIMER;
        if (pif.ext_int) begin
            int_cause = C_INT_EXT;
        end else if (pif.soft_int) begin
            int_cause = C_INT_SOFT;
        end
    end

    assign tvec_base = {pif.mtvec[31:2], 2'b00};

`ifdef PRV_VECTORED_TRAP_EN
    // vectored mode offsets interrupts by 4*cause; exceptions always use the base
    assign trap_tgt = (intr_r && (pif.mtvec[1:0] == 2'b01))
                    ? tvec_base + {cause_r[29:0], 2'b00}
                    : tvec_base;
`else
    // direct mode only: mode bits are not interpreted
    logic unused_mode;
    assign unused_mode = ^pif.mtvec[1:0];
    assign trap_tgt    = tvec_base;
`endif

    // redirect target by the kind of event latched at request time
    always_comb begin
        redirect_pc = trap_tgt;
        case (kind)
            K_MRET:  redirect_pc = pif.mepc;
            K_SRET:  redirect_pc = pif.sepc;
            default: redirect_pc = trap_tgt;
        endcase
    end

    // sequencer: arbitrate in IDLE/SLEEP, hold through DRAIN, one-cycle REDIRECT
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= ST_IDLE;
            kind      <= K_TRAP;
            cause_r   <= '0;
            epc_r     <= '0;
            tval_r    <= '0;
            intr_r    <= 1'b0;
            priv_pc_r <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_SLEEP: begin
                    if (exc_vld) begin
                        cause_r <= exc_cause;
                        epc_r   <= pif.epc;
                        tval_r  <= exc_tval;
                        intr_r  <= 1'b0;
                        kind    <= K_TRAP;
                        state   <= ST_DRAIN;
                    end else if (int_take) begin
                        cause_r <= int_cause;
                        epc_r   <= pif.epc;
                        tval_r  <= '0;
                        intr_r  <= 1'b1;
                        kind    <= K_TRAP;
                        state   <= ST_DRAIN;
                    end else if (state == ST_SLEEP) begin
                        // a masked interrupt still wakes the core, without a trap
                        if (int_pend) begin
                            state <= ST_IDLE;
                        end
                    end else if (pif.mret) begin
                        intr_r <= 1'b0;
                        kind   <= K_MRET;
                        state  <= ST_DRAIN;
                    end else if (pif.sret) begin
                        intr_r <= 1'b0;
                        kind   <= K_SRET;
                        state  <= ST_DRAIN;
                    end else if (pif.wfi) begin
                        state  <= ST_SLEEP;
                    end
                end
                ST_DRAIN: begin
                    if (pif.pipe_clear) begin
                        priv_pc_r <= redirect_pc;
                        state     <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // strobes are pure decodes of REDIRECT so each lasts exactly one cycle
    assign pif.insert_pc = (state == ST_REDIRECT);
    assign pif.trap_take = (state == ST_REDIRECT) && (kind == K_TRAP);
    assign pif.mret_take = (state == ST_REDIRECT) && (kind == K_MRET);
    assign pif.sret_take = (state == ST_REDIRECT) && (kind == K_SRET);

    assign pif.priv_pc   = priv_pc_r;
    assign pif.intr      = intr_r;
    assign pif.cause_out = cause_r;
    assign pif.epc_out   = epc_r;
    assign pif.tval_out  = tval_r;

endmodule

// File: doc/prv_trap_ctrl.md
# prv_trap_ctrl

Trap sequencer on the privilege-block side of the privilege/pipeline connection. It consumes the exception, xRET and WFI flags that the hazard unit drives, plus interrupt lines, and arbitrates them. It waits for the pipeline to drain, then returns the redirect (`priv_pc`, `insert_pc`, `intr`) along with one-cycle CSR update strobes (cause, epc, tval) to the CSR file.

## Interface
- No parameters; word width fixed at 32 (`word_t`).
- `CLK` in 1: clock.
- `nRST` in 1: asynchronous, active-low reset.
- `fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env, fault_insn_page, fault_load_page, fault_store_page` in 1 each: exception flags from the hazard unit.
- `mret, sret, wfi` in 1 each: xRET and WFI requests.
- `pipe_clear` in 1: pipeline drained.
- `epc, badaddr` in 32: faulting PC and faulting address.
- `timer_int, soft_int, ext_int` in 1 each: pending interrupts, already masked by `mie`.
- `mstatus_mie` in 1: global interrupt enable.
- `curr_privilege_level` in 2: current privilege; encodes U=0, S=1, M=3.
- `mtvec, mepc, sepc` in 32 each: CSR values.
- `priv_pc` out 32: redirect target.
- `insert_pc` out 1: redirect strobe.
- `intr` out 1: the taken trap is an interrupt.
- `trap_take` out 1: CSR file latches cause, epc and tval.
- `mret_take, sret_take` out 1 each: CSR file pops status.
- `cause_out` out 32: bit 31 is the interrupt flag.
- `epc_out, tval_out` out 32: values for the CSR file.

## Operation
- FSM states: IDLE, DRAIN, REDIRECT, SLEEP.
- IDLE with any exception flag set:
  - latch cause by priority: breakpoint 3, fault_insn_page 12, fault_insn 1, mal_insn 0, illegal_insn 2, env (8/9/11 for U/S/M), mal_s 6, mal_l 4, fault_store_page 15, fault_load_page 13, fault_s 7, fault_l 5;
  - latch `epc`; tval = `epc` for instruction faults, `badaddr` for load/store faults, 0 otherwise;
  - go to DRAIN.
- Exceptions beat interrupts. Interrupts beat mret, mret beats sret, sret beats wfi.
- IDLE with no exception and `mstatus_mie`=1 with an interrupt pending:
  - cause = 0x8000000B (ext) > 0x80000003 (soft) > 0x80000007 (timer);
  - epc latched; tval=0; `intr` latched=1; go to DRAIN.
- IDLE with mret/sret: latch the return kind; go to DRAIN.
- IDLE with wfi alone: go to SLEEP.
- DRAIN: hold latched values; when `pipe_clear`=1, go to REDIRECT.
- REDIRECT, one cycle, then IDLE:
  - `insert_pc`=1;
  - trap: `priv_pc` = trap target (see Configuration), `trap_take`=1;
  - mret: `priv_pc`=`mepc`, `mret_take`=1;
  - sret: `priv_pc`=`sepc`, `sret_take`=1.
- SLEEP:
  - any of `timer_int/soft_int/ext_int` with `mstatus_mie`=1: take the interrupt as in IDLE (→ DRAIN);
  - interrupt with `mstatus_mie`=0: return to IDLE, no redirect;
  - an exception flag in SLEEP is handled as in IDLE.
- New requests arriving in DRAIN/REDIRECT are ignored. The hazard unit holds them until the pipeline restarts.

## Timing
- Reset values: state IDLE; all outputs 0, including `priv_pc`, `cause_out`, `epc_out`, `tval_out`.
- `cause_out/epc_out/tval_out/intr` are registered. They change only on the IDLE/SLEEP→DRAIN transition and hold until the next one.
- `insert_pc`, `trap_take`, `mret_take` and `sret_take` are combinational decodes of REDIRECT. Each is high for exactly one cycle.
- Latency from request to `insert_pc`:
  - minimum 2 cycles (request cycle N, `pipe_clear` at N+1, redirect at N+2);
  - otherwise 1 cycle after the first `pipe_clear`.
- `nRST` low mid-trap aborts to IDLE immediately. No strobe issues.

## Configuration
- `PRV_VECTORED_TRAP_EN` defined:
  - `mtvec[1:0]`=01 with an interrupt gives `priv_pc` = (`mtvec` & ~3) + 4*cause[30:0];
  - exceptions, or mode 00, go to `mtvec` & ~3.
- Undefined: `priv_pc` = `mtvec` & ~3 for every trap; mode bits ignored.

## Test plan
- illegal_insn=1, epc=0x100, pipe_clear at +1, mtvec=0x800 → insert_pc at +2, priv_pc=0x800, cause_out=2, tval_out=0x100, epc_out=0x100.
- fault_l=1 with mal_s=1, badaddr=0x2003 → cause_out=6, tval_out=0x2003, single trap_take.
- mstatus_mie=1, timer_int=ext_int=1, mtvec=0x801 → cause_out=0x8000000B, intr=1.
  - with macro: priv_pc=0x82C;
  - without macro: priv_pc=0x800.
- mret=1, mepc=0x400, pipe_clear delayed 5 cycles → insert_pc one cycle after pipe_clear, priv_pc=0x400, mret_take=1, trap_take=0.
- wfi, then soft_int with mstatus_mie=0 → leave SLEEP with no insert_pc. Repeat with mie=1 → cause_out=0x80000003.
- nRST low in DRAIN → all outputs 0; no insert_pc after release.
